// File: rtl/cpu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle cpu_seq datapath.
package cpu_seq_pkg;

    localparam logic [3:0] OP_INC   = 4'h0;
    localparam logic [3:0] OP_DEC   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_MOV   = 4'h4;
    localparam logic [3:0] OP_STORE = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_LAND  = 4'h7;
    localparam logic [3:0] OP_LOR   = 4'h8;
    localparam logic [3:0] OP_AND   = 4'h9;
    localparam logic [3:0] OP_OR    = 4'hA;
    localparam logic [3:0] OP_XNOR  = 4'hB;
    localparam logic [3:0] OP_ROR   = 4'hC;
    localparam logic [3:0] OP_ROL   = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Opcodes whose ALU result may be written back to the register file.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_MOV) || ((op >= OP_LAND) && (op <= OP_ROL));
    endfunction

endpackage

// File: rtl/cpu_seq_alu.sv
// Combinational ALU: result plus carry/borrow and signed overflow for the arithmetic ops.
module cpu_seq_alu
    import cpu_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              v
);

    logic              sub;
    logic [DATA_W-1:0] addend;
    logic [DATA_W:0]   sum;
    logic              c_msb;

    // One adder serves INC/DEC/ADD/SUB; subtraction is a + ~b + 1.
    always_comb begin
        sub    = (op == OP_SUB) || (op == OP_DEC);
        addend = ((op == OP_INC) || (op == OP_DEC)) ? DATA_W'(1) : b;
        if (sub) addend = ~addend;
        sum   = {1'b0, a} + {1'b0, addend} + (DATA_W+1)'(sub);
        c_msb = a[DATA_W-1] ^ addend[DATA_W-1] ^ sum[DATA_W-1];
    end

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_INC, OP_ADD: begin
                y = sum[DATA_W-1:0];
                c = sum[DATA_W];
                v = c_msb ^ sum[DATA_W];
            end
            OP_DEC, OP_SUB: begin
                y = sum[DATA_W-1:0];
                c = ~sum[DATA_W];
                v = c_msb ^ sum[DATA_W];
            end
            OP_MOV:  y = b;
            OP_LAND: y = {{(DATA_W-1){1'b0}}, (|a) && (|b)};
            OP_LOR:  y = {{(DATA_W-1){1'b0}}, (|a) || (|b)};
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XNOR: y = ~(a ^ b);
            OP_ROR:  y = {a[0], a[DATA_W-1:1]};
            OP_ROL:  y = {a[DATA_W-2:0], a[DATA_W-1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle cpu: register file, synchronous data RAM and ALU sequenced by a small FSM.
//   state   | meaning
//   IDLE    | in_ready=1, waiting for an instruction
//   EXEC    | ALU/STORE result registered, LOAD read issued
//   MEM     | LOAD data written to R[op1] and y
//   DONE    | result presented; out_valid held until out_ready
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int MEM_AW = 10,
    parameter int ALU_WB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [REG_AW-1:0] op1,
    input  logic [REG_AW-1:0] op2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y,
    output logic              c,
    output logic              v,
    output logic              z
);

    localparam int NREGS = 2 ** REG_AW;

    state_t            state, state_nx;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] dst_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] ram [2**MEM_AW];
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c, alu_v;

    cpu_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (alu_y),
        .c  (alu_c),
        .v  (alu_v)
    );

    always_comb begin
        state_nx = state;
        in_ready = (state == ST_IDLE);
        case (state)
            ST_IDLE: if (in_valid) state_nx = ST_EXEC;
            ST_EXEC: state_nx = (op_q == OP_LOAD) ? ST_MEM : ST_DONE;
            ST_MEM:  state_nx = ST_DONE;
            ST_DONE: if (out_valid && out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            y         <= '0;
            c         <= 1'b0;
            v         <= 1'b0;
            z         <= 1'b0;
            op_q      <= '0;
            dst_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= DATA_W'(i);
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (in_valid) begin
                    op_q  <= op;
                    dst_q <= op1;
                    a_q   <= regs[op1];
                    b_q   <= regs[op2];
                end
                ST_EXEC: if (op_q == OP_STORE) begin
                    y <= a_q;
                    c <= 1'b0;
                    v <= 1'b0;
                    z <= (a_q == '0);
                end else if (op_q != OP_LOAD) begin
                    y <= alu_y;
                    c <= alu_c;
                    v <= alu_v;
                    z <= (alu_y == '0);
                    if ((ALU_WB != 0) && is_alu_op(op_q)) regs[dst_q] <= alu_y;
                end
                ST_MEM: begin
                    y           <= ram_q;
                    c           <= 1'b0;
                    v           <= 1'b0;
                    z           <= (ram_q == '0);
                    regs[dst_q] <= ram_q;
                end
                // out_valid rises one edge after entering DONE, so results appear
                // two edges after acceptance (three for LOAD).
                ST_DONE: out_valid <= !(out_valid && out_ready);
                default: out_valid <= 1'b0;
            endcase
        end
    end

    // RAM has no reset; gating on rst_n keeps an aborted STORE from landing.
    always_ff @(posedge clk) begin
        if (rst_n && (state == ST_EXEC)) begin
            if (op_q == OP_STORE) ram[b_q[MEM_AW-1:0]] <= a_q;
            ram_q <= ram[b_q[MEM_AW-1:0]];
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// Directed bench for cpu_seq: architectural model of regs/RAM, per-cycle compare, literal pins.
module tb_cpu_seq;

    localparam int W = 16;
    localparam logic [3:0] INC = 4'h0, DEC = 4'h1, SUB = 4'h2, ADD = 4'h3, MOV = 4'h4,
                           STO = 4'h5, LDM = 4'h6, LAND = 4'h7, LOR = 4'h8, BAND = 4'h9,
                           BOR = 4'hA, XNR = 4'hB, ROR = 4'hC, ROL = 4'hD, RSV = 4'hE;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, c, v, z;
    logic [3:0]   op = '0;
    logic [2:0]   op1 = '0, op2 = '0;
    logic [W-1:0] y;

    int checks = 0, failures = 0;

    cpu_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .c(c), .v(v), .z(z)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_reg [8];
    logic [W-1:0] m_ram [int];
    logic [W-1:0] e_y;
    logic         e_c, e_v, e_z;
    bit           pending = 0, chk_en = 0, exp_ov;
    int           age = 0, lat = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = W'(i);
    endtask

    // Architectural effect of one instruction, from plain integer arithmetic.
    task automatic model(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s);
        logic [W-1:0] a, b;
        int sa, sb, sr;
        bit wb;
        a = m_reg[d]; b = m_reg[s];
        if (o == INC || o == DEC) b = 1;
        sa = int'($signed(a)); sb = int'($signed(b));
        e_c = 0; e_v = 0; wb = 1;
        case (o)
            INC, ADD: begin
                e_y = W'(int'(a) + int'(b));
                e_c = (int'(a) + int'(b)) > 65535;
                sr  = sa + sb;
                e_v = (sr > 32767) || (sr < -32768);
            end
            DEC, SUB: begin
                e_y = W'(int'(a) - int'(b));
                e_c = a < b;
                sr  = sa - sb;
                e_v = (sr > 32767) || (sr < -32768);
            end
            MOV:  e_y = b;
            STO:  begin e_y = a; m_ram[int'(b[9:0])] = a; wb = 0; end
            LDM:  e_y = m_ram.exists(int'(b[9:0])) ? m_ram[int'(b[9:0])] : 'x;
            LAND: e_y = W'((a != 0) && (b != 0));
            LOR:  e_y = W'((a != 0) || (b != 0));
            BAND: e_y = a & b;
            BOR:  e_y = a | b;
            XNR:  e_y = ~(a ^ b);
            ROR:  e_y = (a >> 1) | (a << (W-1));
            ROL:  e_y = (a << 1) | (a >> (W-1));
            default: begin e_y = 0; wb = 0; end
        endcase
        e_z = (e_y == 0);
        if (wb) m_reg[d] = e_y;
        lat = (o == LDM) ? 3 : 2;
    endtask

    // Issue one instruction, then hold out_ready low for `hold` cycles with in_valid toggled on.
    task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s,
                         input int hold);
        int n;
        @(negedge clk);
        op = o; op1 = d; op2 = s; in_valid = 1;
        @(posedge clk);
        model(o, d, s);
        age = 0; pending = 1;
        #1;
        in_valid = 0; op = 4'($urandom); op1 = 3'($urandom); op2 = 3'($urandom);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("out_valid_timeout", 0, 1);
        repeat (hold) begin
            @(negedge clk);
            in_valid = 1; op = ADD; op1 = 3'd7; op2 = 3'd7;
        end
        @(negedge clk);
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        pending = 0;
        #1 out_ready = 0;
    endtask

    // Accept an instruction, then assert reset during its EXEC cycle.
    task automatic abort(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s);
        @(negedge clk);
        op = o; op1 = d; op2 = s; in_valid = 1;
        @(posedge clk);
        age = 0; pending = 1; lat = 3;
        #1 in_valid = 0;
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        pending = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (pending) age++;
                exp_ov = pending && (age > lat);
                check("in_ready", in_ready, !pending);
                check("out_valid", out_valid, exp_ov);
                if (exp_ov) begin
                    check("y", y, e_y);
                    check("c", c, e_c);
                    check("v", v, e_v);
                    check("z", z, e_z);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_cvz", {c, v, z}, 0);
        chk_en = 1;

        issue(ADD, 1, 2, 0);
        check("add_y", y, 3);
        check("add_cvz", {c, v, z}, 3'b000);
        issue(STO, 4, 5, 0);
        check("store_y", y, 4);
        issue(LDM, 6, 5, 0);
        check("load_y", y, 4);
        issue(DEC, 0, 0, 0);
        check("dec_y", y, 16'hFFFF);
        check("dec_cvz", {c, v, z}, 3'b100);
        issue(DEC, 2, 2, 0);
        issue(ROR, 2, 2, 0);
        check("ror_y", y, 16'h8000);
        issue(ROL, 2, 2, 0);
        check("rol_y", y, 16'h0001);
        issue(MOV, 5, 2, 0);
        issue(ROR, 2, 2, 0);
        issue(DEC, 2, 2, 0);
        check("dec_ovf_y", y, 16'h7FFF);
        issue(STO, 2, 7, 0);
        issue(LDM, 3, 7, 0);
        check("load_7fff", y, 16'h7FFF);
        issue(ADD, 3, 5, 3);
        check("add_ovf_y", y, 16'h8000);
        check("add_ovf_cvz", {c, v, z}, 3'b010);
        issue(INC, 0, 0, 0);
        issue(LAND, 0, 3, 0);
        check("land_y", y, 0);
        check("land_z", z, 1);
        issue(RSV, 1, 2, 5);
        check("rsv_y", y, 0);
        check("rsv_z", z, 1);
        issue(MOV, 6, 1, 0);
        check("rsv_no_wb", y, 3);
        issue(SUB, 4, 7, 0);
        issue(LOR, 0, 7, 0);
        issue(BAND, 7, 6, 0);
        issue(BOR, 4, 2, 0);
        issue(XNR, 7, 7, 0);
        issue(SUB, 1, 1, 0);
        issue(4'hF, 4, 4, 2);

        abort(LDM, 6, 5);
        issue(MOV, 0, 6, 0);
        check("abort_load_no_wb", y, 6);
        abort(STO, 1, 7);
        issue(LDM, 2, 7, 0);
        check("abort_store_no_write", y, 16'h7FFF);

        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
